// File: rtl/hazard_fwd_unit_pkg.sv
// Shared encodings for the forwarding/hazard unit: forward selects, control opcodes, stall FSM states.
// Pure definitions, no logic or timing of its own.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [5:0] OP_JR   = 6'd8;
    localparam logic [5:0] OP_CALL = 6'd9;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_STALL = 2'd1,
        CTRL_STALL = 2'd2
    } stall_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side bundle of the hazard unit; HAZARD_STATS_EN adds the two stall statistics counters.
// Master drives the pipeline register fields, slave (the unit) returns selects and stall.
interface hazard_fwd_unit_if #(
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC*REG_W-1:0] id_ex_rs;
    logic [REG_W-1:0]         id_ex_rd;
    logic [REG_W-1:0]         ex_mem_rd;
    logic [REG_W-1:0]         mem_wb_rd;
    logic                     id_ex_regwrite;
    logic                     ex_mem_regwrite;
    logic                     mem_wb_regwrite;
    logic                     id_ex_memrd;
    logic                     mem_wb_datawrite;
    logic [5:0]               opcode;
    logic                     exception;
    logic [2*NUM_SRC-1:0]     fwd_sel;
    logic                     stall;
    logic [1:0]               stall_state;
`ifdef HAZARD_STATS_EN
    logic [15:0]              load_stall_cycles;
    logic [15:0]              ctrl_stall_cycles;
`endif

    modport master (
`ifdef HAZARD_STATS_EN
        input  load_stall_cycles, ctrl_stall_cycles,
`endif
        output id_ex_rs, id_ex_rd, ex_mem_rd, mem_wb_rd,
        output id_ex_regwrite, ex_mem_regwrite, mem_wb_regwrite,
        output id_ex_memrd, mem_wb_datawrite, opcode, exception,
        input  fwd_sel, stall, stall_state
    );

    modport slave (
`ifdef HAZARD_STATS_EN
        output load_stall_cycles, ctrl_stall_cycles,
`endif
        input  id_ex_rs, id_ex_rd, ex_mem_rd, mem_wb_rd,
        input  id_ex_regwrite, ex_mem_regwrite, mem_wb_regwrite,
        input  id_ex_memrd, mem_wb_datawrite, opcode, exception,
        output fwd_sel, stall, stall_state
    );
endinterface

// File: rtl/hazard_fwd_unit_fwd_select.sv
// Single-channel forward selector, youngest producing stage wins; register 0 never forwards.
// Purely combinational, zero latency, no backpressure.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic [REG_W-1:0] mem_wb_rd,
    input  logic             id_ex_regwrite,
    input  logic             ex_mem_regwrite,
    input  logic             mem_wb_regwrite,
    input  logic             mem_wb_datawrite,
    output logic [1:0]       sel
);

    always_comb begin
        sel = FWD_RF;
        if (id_ex_regwrite && (id_ex_rd != '0) && (id_ex_rd == rs)) begin
            sel = FWD_EX;
        end else if (ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (mem_wb_regwrite && !mem_wb_datawrite &&
                     (mem_wb_rd != '0) && (mem_wb_rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Per-operand forwarding plus counted load-use / JR-CALL stall FSM; fwd_sel zero latency, first stall cycle combinational.
// Exception or reset drops stall immediately; HAZARD_STATS_EN adds saturating stall-cycle counters.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_W        = 4,
    parameter int NUM_SRC      = 2,
    parameter int LOAD_LAT     = 1,
    parameter int CTRL_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    hazard_fwd_unit_if.slave  bus
);

    localparam int MAX_LAT = max_int(LOAD_LAT, CTRL_BUBBLES);
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    logic [2*NUM_SRC-1:0] sel;
    logic                 load_hz;
    logic                 ctrl_hz;
    logic [CNT_W-1:0]     load_len;
    logic [CNT_W-1:0]     cnt;
    stall_state_t         state;
    logic                 stall;

    for (genvar ch = 0; ch < NUM_SRC; ch++) begin : g_ch
        fwd_select #(.REG_W(REG_W)) u_fwd_select (
            .rs               (bus.id_ex_rs[ch*REG_W +: REG_W]),
            .id_ex_rd         (bus.id_ex_rd),
            .ex_mem_rd        (bus.ex_mem_rd),
            .mem_wb_rd        (bus.mem_wb_rd),
            .id_ex_regwrite   (bus.id_ex_regwrite),
            .ex_mem_regwrite  (bus.ex_mem_regwrite),
            .mem_wb_regwrite  (bus.mem_wb_regwrite),
            .mem_wb_datawrite (bus.mem_wb_datawrite),
            .sel              (sel[2*ch +: 2])
        );
    end

    always_comb begin
        load_hz = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel[2*i +: 2] == FWD_EX) begin
                load_hz = 1'b1;
            end
        end
        load_hz = load_hz & bus.id_ex_memrd;
        ctrl_hz = ((bus.opcode == OP_JR) || (bus.opcode == OP_CALL)) && !bus.exception;
        // A simultaneous control hazard stretches the load stall to cover both.
        load_len = ctrl_hz ? CNT_W'(MAX_LAT - 1) : CNT_W'(LOAD_LAT - 1);
    end

    always_comb begin
        stall = 1'b0;
        if (!reset && !bus.exception) begin
            stall = (state != IDLE) || load_hz || ctrl_hz;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.exception) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_hz && (load_len != '0)) begin
                        state <= LOAD_STALL;
                        cnt   <= load_len;
                    end else if (ctrl_hz && !load_hz && (CTRL_BUBBLES > 1)) begin
                        state <= CTRL_STALL;
                        cnt   <= CNT_W'(CTRL_BUBBLES - 1);
                    end
                end
                LOAD_STALL, CTRL_STALL: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.fwd_sel     = sel;
    assign bus.stall       = stall;
    assign bus.stall_state = state;

`ifdef HAZARD_STATS_EN
    logic [15:0] load_cycles;
    logic [15:0] ctrl_cycles;

    // In IDLE the cycle is charged to load whenever a load hazard is present.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cycles <= '0;
            ctrl_cycles <= '0;
        end else if (stall) begin
            if ((state == LOAD_STALL) || ((state == IDLE) && load_hz)) begin
                if (load_cycles != 16'hFFFF) load_cycles <= load_cycles + 16'd1;
            end else begin
                if (ctrl_cycles != 16'hFFFF) ctrl_cycles <= ctrl_cycles + 16'd1;
            end
        end
    end

    assign bus.load_stall_cycles = load_cycles;
    assign bus.ctrl_stall_cycles = ctrl_cycles;
`endif

endmodule
